// File: rtl/mp3_pkg.sv
// Shared definitions for the MP3 flash-to-parser path: streamer FSM states,
// byte-lane names and the flash word-address width.
package mp3_pkg;

  localparam int FLASH_ADDR_W = 23;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EMIT,
    DONE,
    DRAIN
  } state_e;

  localparam logic [1:0] FIRST  = 2'd0;
  localparam logic [1:0] SECOND = 2'd1;
  localparam logic [1:0] THIRD  = 2'd2;
  localparam logic [1:0] FOURTH = 2'd3;

  // Little-endian lane pick: lane 0 is bits [7:0].
  function automatic logic [7:0] select_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/flash_byte_streamer_if.sv
// Flash read port plus outgoing byte stream; master is the streamer side.
interface flash_byte_streamer_if #(
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_read;
  logic              flash_waitrequest;
  logic              flash_readdatavalid;
  logic [31:0]       flash_readdata;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output flash_addr, flash_read, byte_data, byte_valid,
    input  flash_waitrequest, flash_readdatavalid, flash_readdata, byte_ready
  );

  modport slave (
    input  flash_addr, flash_read, byte_data, byte_valid,
    output flash_waitrequest, flash_readdatavalid, flash_readdata, byte_ready
  );
endinterface

// File: rtl/flash_byte_streamer_address_select.sv
// Byte/word stepping rule: four lanes per word, word moves by WORD_DELTA
// when the lane wraps (3->0 forward, 0->3 reverse).
module address_select
  import mp3_pkg::*;
#(
  parameter int ADDR_W     = FLASH_ADDR_W,
  parameter int WORD_DELTA = 1
) (
  input  logic              reverse,
  input  logic [ADDR_W-1:0] word_i,
  input  logic [1:0]        lane_i,
  output logic [ADDR_W-1:0] word_o,
  output logic [1:0]        lane_o,
  output logic              word_step_o
);

  localparam logic [ADDR_W-1:0] DELTA = ADDR_W'(WORD_DELTA);

  always_comb begin
    word_o      = word_i;
    lane_o      = lane_i;
    word_step_o = 1'b0;
    if (reverse) begin
      case (lane_i)
        FOURTH:  lane_o = THIRD;
        THIRD:   lane_o = SECOND;
        SECOND:  lane_o = FIRST;
        default: begin
          lane_o      = FOURTH;
          word_o      = word_i - DELTA;
          word_step_o = 1'b1;
        end
      endcase
    end else begin
      case (lane_i)
        FIRST:   lane_o = SECOND;
        SECOND:  lane_o = THIRD;
        THIRD:   lane_o = FOURTH;
        default: begin
          lane_o      = FIRST;
          word_o      = word_i + DELTA;
          word_step_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/flash_byte_streamer.sv
// Fetches 32-bit flash words one at a time and emits their bytes forward or
// reverse between a start and an inclusive end word.
module flash_byte_streamer
  import mp3_pkg::*;
#(
  parameter int WORD_DELTA = 1,
  parameter int ADDR_W     = FLASH_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  reverse,
  input  logic [ADDR_W-1:0]     start_word,
  input  logic [ADDR_W-1:0]     end_word,
  output logic                  busy,
  output logic                  done,
  flash_byte_streamer_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] word_q;
  logic [ADDR_W-1:0] end_word_q;
  logic [1:0]        lane_q;
  logic              reverse_q;
  logic [31:0]       buffer_q;
  logic              flash_read_q;
  logic [ADDR_W-1:0] flash_addr_q;
  logic              byte_valid_q;
  logic [7:0]        byte_data_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] word_d;
  logic [1:0]        lane_d;
  logic              word_step_d;
  logic              last_byte;

  address_select #(
    .ADDR_W    (ADDR_W),
    .WORD_DELTA(WORD_DELTA)
  ) u_address_select (
    .reverse    (reverse_q),
    .word_i     (word_q),
    .lane_i     (lane_q),
    .word_o     (word_d),
    .lane_o     (lane_d),
    .word_step_o(word_step_d)
  );

  assign last_byte = (word_q == end_word_q) && (lane_q == (reverse_q ? FIRST : FOURTH));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      end_word_q   <= '0;
      lane_q       <= FIRST;
      reverse_q    <= 1'b0;
      buffer_q     <= '0;
      flash_read_q <= 1'b0;
      flash_addr_q <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            word_q       <= start_word;
            end_word_q   <= end_word;
            reverse_q    <= reverse;
            lane_q       <= reverse ? FOURTH : FIRST;
            flash_read_q <= 1'b1;
            flash_addr_q <= start_word;
            busy_q       <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (!bus.flash_waitrequest) begin
            // Accepted even if stop is high: the word is now in flight.
            flash_read_q <= 1'b0;
            state_q      <= stop ? DRAIN : WAIT_DATA;
          end else if (stop) begin
            flash_read_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        WAIT_DATA: begin
          if (bus.flash_readdatavalid) begin
            if (stop) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              buffer_q     <= bus.flash_readdata;
              byte_data_q  <= select_lane(bus.flash_readdata, lane_q);
              byte_valid_q <= 1'b1;
              state_q      <= EMIT;
            end
          end else if (stop) begin
            state_q <= DRAIN;
          end
        end
        EMIT: begin
          if (stop) begin
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else if (bus.byte_ready) begin
            if (last_byte) begin
              byte_valid_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= DONE;
            end else begin
              word_q <= word_d;
              lane_q <= lane_d;
              if (word_step_d) begin
                byte_valid_q <= 1'b0;
                flash_read_q <= 1'b1;
                flash_addr_q <= word_d;
                state_q      <= REQ;
              end else begin
                byte_data_q <= select_lane(buffer_q, lane_d);
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        DRAIN: begin
          if (bus.flash_readdatavalid) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          flash_read_q <= 1'b0;
          byte_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.flash_read = flash_read_q;
  assign bus.flash_addr = flash_addr_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_flash_byte_streamer.sv
// Bench for flash_byte_streamer: acts as flash controller and byte sink, and
// checks each stream against a word-list model of the expected bytes.
module tb_flash_byte_streamer;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, reverse, busy, done;
  logic [22:0] start_word, end_word;

  always #5 clk = ~clk;

  flash_byte_streamer_if #(.ADDR_W(23)) bus ();

  flash_byte_streamer #(.WORD_DELTA(1), .ADDR_W(23)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .reverse   (reverse),
    .start_word(start_word),
    .end_word  (end_word),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  logic [31:0] mem [logic [22:0]];
  logic [22:0] got_reads[$], exp_reads[$];
  logic [7:0]  got_bytes[$], exp_bytes[$];
  int done_cnt, viol, first_ok, timeout;
  int n_cmp = 0, n_err = 0;

  // Model: the word sequence is start +/- i up to the end word, each word
  // contributing its four little-endian bytes in stream order.
  task automatic build_expected(input logic [22:0] sw, input logic [22:0] ew, input logic rev);
    logic [22:0] span, w;
    logic [31:0] d;
    int lane;
    exp_reads.delete();
    exp_bytes.delete();
    span = rev ? sw - ew : ew - sw;
    for (int i = 0; i <= int'(span); i++) begin
      w = rev ? sw - 23'(i) : sw + 23'(i);
      exp_reads.push_back(w);
      d = mem.exists(w) ? mem[w] : 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
        lane = rev ? 3 - k : k;
        exp_bytes.push_back(d[8*lane +: 8]);
      end
    end
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random.
  // wait_hold >= 0 holds waitrequest that many cycles per read, -1 random.
  task automatic run_stream(input logic [22:0] sw, input logic [22:0] ew, input logic rev,
                            input int ready_mode, input int wait_hold, input int max_lat);
    bit pend = 0, prev_rdv = 0, prev_stall = 0, prev_wait = 0, wr, rdy;
    bit exp_req_next = 0, exp_done_next = 0, exp_idle_next = 0;
    int cnt = 0, hold = 0, total;
    logic [22:0] pend_addr = '0, prev_addr = '0;
    logic [7:0]  prev_byte = '0;
    got_reads.delete();
    got_bytes.delete();
    done_cnt = 0; viol = 0; timeout = 1; first_ok = 0;
    build_expected(sw, ew, rev);
    total = exp_bytes.size();
    @(negedge clk);
    start_word = sw; end_word = ew; reverse = rev; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_word = 23'($urandom); end_word = 23'($urandom); reverse = 1'($urandom);
    first_ok = (bus.flash_read === 1'b1 && bus.flash_addr === sw) ? 1 : 0;
    for (int c = 0; c < 1000; c++) begin
      if (exp_req_next && bus.flash_read !== 1'b1) viol++;
      if (exp_done_next && done !== 1'b1) viol++;
      if (exp_idle_next && busy !== 1'b0) viol++;
      if (prev_rdv && bus.byte_valid !== 1'b1) viol++;
      if (prev_stall && (bus.byte_valid !== 1'b1 || bus.byte_data !== prev_byte)) viol++;
      if (prev_wait && (bus.flash_read !== 1'b1 || bus.flash_addr !== prev_addr)) viol++;
      exp_req_next = 0; exp_done_next = 0; exp_idle_next = 0;
      if (done === 1'b1) begin
        done_cnt++;
        exp_idle_next = 1;
      end
      if (busy === 1'b0) begin
        timeout = 0;
        break;
      end
      bus.flash_readdatavalid = 1'b0;
      bus.flash_readdata = $urandom;
      prev_rdv = 0;
      if (pend) begin
        if (cnt == 0) begin
          bus.flash_readdatavalid = 1'b1;
          bus.flash_readdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'hDEADBEEF;
          pend = 0;
          prev_rdv = 1;
        end else begin
          cnt--;
        end
      end
      prev_wait = 0;
      if (bus.flash_read === 1'b1) begin
        if (wait_hold >= 0) wr = (hold < wait_hold);
        else wr = ($urandom_range(0, 2) == 0);
        if (wr) begin
          bus.flash_waitrequest = 1'b1;
          hold++;
          prev_wait = 1;
          prev_addr = bus.flash_addr;
        end else begin
          bus.flash_waitrequest = 1'b0;
          hold = 0;
          got_reads.push_back(bus.flash_addr);
          pend = 1;
          pend_addr = bus.flash_addr;
          cnt = $urandom_range(0, max_lat);
        end
      end else begin
        bus.flash_waitrequest = 1'($urandom);
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((c % 2) == 0);
        default: rdy = 1'($urandom);
      endcase
      bus.byte_ready = rdy;
      prev_stall = 0;
      if (bus.byte_valid === 1'b1) begin
        if (rdy) begin
          got_bytes.push_back(bus.byte_data);
          if (got_bytes.size() == total) exp_done_next = 1;
          else if (got_bytes.size() % 4 == 0) exp_req_next = 1;
        end else begin
          prev_stall = 1;
          prev_byte = bus.byte_data;
        end
      end
      @(negedge clk);
    end
    bus.flash_readdatavalid = 1'b0;
    bus.flash_waitrequest = 1'b0;
    bus.byte_ready = 1'b0;
    $display("stream start=%06h end=%06h rev=%0d reads=%0d bytes=%0d done=%0d",
             sw, ew, rev, got_reads.size(), got_bytes.size(), done_cnt);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.flash_addr !== 23'd0) begin n_err++; $display("FAIL rst_flash_addr: got %h expected 0", bus.flash_addr); end
    n_cmp++; if (bus.flash_read !== 1'b0) begin n_err++; $display("FAIL rst_flash_read: got %b expected 0", bus.flash_read); end
    n_cmp++; if (bus.byte_data !== 8'd0) begin n_err++; $display("FAIL rst_byte_data: got %h expected 0", bus.byte_data); end
    n_cmp++; if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL rst_byte_valid: got %b expected 0", bus.byte_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
    reset_n = 1'b1;
    start_word = 23'h40; end_word = 23'h40; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0 || bus.flash_read !== 1'b0) begin n_err++; $display("FAIL start_stop_idle: got busy=%b read=%b expected 0/0", busy, bus.flash_read); end
  endtask

  task automatic test_forward();
    string t = "fwd";
    mem[23'h10] = 32'h44332211; mem[23'h11] = 32'h88776655;
    run_stream(23'h10, 23'h11, 1'b0, 0, 0, 2);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL %s_timeout: got stuck=%0d expected 0", t, timeout); end
    n_cmp++; if (first_ok !== 1) begin n_err++; $display("FAIL %s_first_read: got ok=%0d expected 1", t, first_ok); end
    n_cmp++; if (got_reads.size() !== exp_reads.size()) begin n_err++; $display("FAIL %s_nreads: got %0d expected %0d", t, got_reads.size(), exp_reads.size()); end
    foreach (exp_reads[i]) if (i < got_reads.size()) begin n_cmp++; if (got_reads[i] !== exp_reads[i]) begin n_err++; $display("FAIL %s_read[%0d]: got %h expected %h", t, i, got_reads[i], exp_reads[i]); end end
    n_cmp++; if (got_bytes.size() !== exp_bytes.size()) begin n_err++; $display("FAIL %s_nbytes: got %0d expected %0d", t, got_bytes.size(), exp_bytes.size()); end
    foreach (exp_bytes[i]) if (i < got_bytes.size()) begin n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_err++; $display("FAIL %s_byte[%0d]: got %h expected %h", t, i, got_bytes[i], exp_bytes[i]); end end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL %s_done: got %0d pulses expected 1", t, done_cnt); end
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL %s_timing: got %0d violations expected 0", t, viol); end
  endtask

  task automatic test_reverse();
    string t = "rev";
    mem[23'h10] = 32'h44332211; mem[23'h11] = 32'h88776655;
    run_stream(23'h11, 23'h10, 1'b1, 0, 0, 2);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL %s_timeout: got stuck=%0d expected 0", t, timeout); end
    n_cmp++; if (first_ok !== 1) begin n_err++; $display("FAIL %s_first_read: got ok=%0d expected 1", t, first_ok); end
    n_cmp++; if (got_reads.size() !== exp_reads.size()) begin n_err++; $display("FAIL %s_nreads: got %0d expected %0d", t, got_reads.size(), exp_reads.size()); end
    foreach (exp_reads[i]) if (i < got_reads.size()) begin n_cmp++; if (got_reads[i] !== exp_reads[i]) begin n_err++; $display("FAIL %s_read[%0d]: got %h expected %h", t, i, got_reads[i], exp_reads[i]); end end
    n_cmp++; if (got_bytes.size() !== exp_bytes.size()) begin n_err++; $display("FAIL %s_nbytes: got %0d expected %0d", t, got_bytes.size(), exp_bytes.size()); end
    foreach (exp_bytes[i]) if (i < got_bytes.size()) begin n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_err++; $display("FAIL %s_byte[%0d]: got %h expected %h", t, i, got_bytes[i], exp_bytes[i]); end end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL %s_done: got %0d pulses expected 1", t, done_cnt); end
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL %s_timing: got %0d violations expected 0", t, viol); end
  endtask

  task automatic test_backpressure();
    string t = "bp";
    mem[23'h10] = 32'h44332211; mem[23'h11] = 32'h88776655;
    run_stream(23'h10, 23'h11, 1'b0, 1, 0, 1);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL %s_timeout: got stuck=%0d expected 0", t, timeout); end
    n_cmp++; if (got_bytes.size() !== exp_bytes.size()) begin n_err++; $display("FAIL %s_nbytes: got %0d expected %0d", t, got_bytes.size(), exp_bytes.size()); end
    foreach (exp_bytes[i]) if (i < got_bytes.size()) begin n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_err++; $display("FAIL %s_byte[%0d]: got %h expected %h", t, i, got_bytes[i], exp_bytes[i]); end end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL %s_done: got %0d pulses expected 1", t, done_cnt); end
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL %s_stall_stability: got %0d violations expected 0", t, viol); end
  endtask

  task automatic test_waitrequest();
    string t = "wait";
    mem[23'h20] = $urandom; mem[23'h21] = $urandom;
    run_stream(23'h20, 23'h21, 1'b0, 0, 5, 0);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL %s_timeout: got stuck=%0d expected 0", t, timeout); end
    n_cmp++; if (got_reads.size() !== exp_reads.size()) begin n_err++; $display("FAIL %s_nreads: got %0d expected %0d", t, got_reads.size(), exp_reads.size()); end
    foreach (exp_reads[i]) if (i < got_reads.size()) begin n_cmp++; if (got_reads[i] !== exp_reads[i]) begin n_err++; $display("FAIL %s_read[%0d]: got %h expected %h", t, i, got_reads[i], exp_reads[i]); end end
    n_cmp++; if (got_bytes.size() !== exp_bytes.size()) begin n_err++; $display("FAIL %s_nbytes: got %0d expected %0d", t, got_bytes.size(), exp_bytes.size()); end
    foreach (exp_bytes[i]) if (i < got_bytes.size()) begin n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_err++; $display("FAIL %s_byte[%0d]: got %h expected %h", t, i, got_bytes[i], exp_bytes[i]); end end
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL %s_req_stability: got %0d violations expected 0", t, viol); end
  endtask

  task automatic test_stop_drain();
    int bad = 0;
    @(negedge clk);
    start_word = 23'h100; end_word = 23'h101; reverse = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (bus.flash_read !== 1'b1) begin n_err++; $display("FAIL stop_req: got read=%b expected 1", bus.flash_read); end
    bus.flash_waitrequest = 1'b0;
    @(negedge clk);
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stop = 1'b0;
      if (bus.byte_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || bus.flash_read !== 1'b0) bad++;
    end
    bus.flash_readdatavalid = 1'b1; bus.flash_readdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.flash_readdatavalid = 1'b0;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL drain_quiet: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_busy_drop: got busy=%b expected 0", busy); end
    n_cmp++; if (bus.byte_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL drain_no_output: got valid=%b done=%b expected 0/0", bus.byte_valid, done); end
    mem[23'h100] = $urandom; mem[23'h101] = $urandom;
    run_stream(23'h100, 23'h101, 1'b0, 2, -1, 2);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL restart_timeout: got stuck=%0d expected 0", timeout); end
    n_cmp++; if (got_bytes.size() !== exp_bytes.size()) begin n_err++; $display("FAIL restart_nbytes: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); end
    foreach (exp_bytes[i]) if (i < got_bytes.size()) begin n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_err++; $display("FAIL restart_byte[%0d]: got %h expected %h", i, got_bytes[i], exp_bytes[i]); end end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL restart_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_wrap();
    string t = "wrap";
    mem[23'h7FFFFF] = $urandom; mem[23'h000000] = $urandom;
    run_stream(23'h7FFFFF, 23'h000000, 1'b0, 2, -1, 3);
    n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL %s_timeout: got stuck=%0d expected 0", t, timeout); end
    n_cmp++; if (got_reads.size() !== exp_reads.size()) begin n_err++; $display("FAIL %s_nreads: got %0d expected %0d", t, got_reads.size(), exp_reads.size()); end
    foreach (exp_reads[i]) if (i < got_reads.size()) begin n_cmp++; if (got_reads[i] !== exp_reads[i]) begin n_err++; $display("FAIL %s_read[%0d]: got %h expected %h", t, i, got_reads[i], exp_reads[i]); end end
    n_cmp++; if (got_bytes.size() !== exp_bytes.size()) begin n_err++; $display("FAIL %s_nbytes: got %0d expected %0d", t, got_bytes.size(), exp_bytes.size()); end
    foreach (exp_bytes[i]) if (i < got_bytes.size()) begin n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_err++; $display("FAIL %s_byte[%0d]: got %h expected %h", t, i, got_bytes[i], exp_bytes[i]); end end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL %s_done: got %0d pulses expected 1", t, done_cnt); end
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL %s_timing: got %0d violations expected 0", t, viol); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    start_word = 23'h5; end_word = 23'h6; reverse = 1'b0; start = 1'b1;
    bus.flash_waitrequest = 1'b0; bus.byte_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bus.flash_readdatavalid = 1'b1; bus.flash_readdata = 32'hA1B2C3D4;
    @(negedge clk);
    bus.flash_readdatavalid = 1'b0;
    n_cmp++; if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'hD4) begin n_err++; $display("FAIL mid_first_byte: got valid=%b data=%h expected 1/d4", bus.byte_valid, bus.byte_data); end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus.byte_valid !== 1'b0 || bus.flash_read !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_reset_ctrl: got busy=%b valid=%b read=%b done=%b expected 0", busy, bus.byte_valid, bus.flash_read, done); end
    n_cmp++; if (bus.byte_data !== 8'd0 || bus.flash_addr !== 23'd0) begin n_err++; $display("FAIL mid_reset_data: got data=%h addr=%h expected 0/0", bus.byte_data, bus.flash_addr); end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [22:0] sw, ew;
    logic        rev;
    int          nw;
    for (int r = 0; r < 6; r++) begin
      sw = 23'($urandom); rev = 1'($urandom); nw = $urandom_range(1, 3);
      ew = rev ? sw - 23'(nw - 1) : sw + 23'(nw - 1);
      for (int i = 0; i < nw; i++) mem[rev ? sw - 23'(i) : sw + 23'(i)] = $urandom;
      run_stream(sw, ew, rev, 2, -1, 3);
      n_cmp++; if (timeout !== 0) begin n_err++; $display("FAIL rnd%0d_timeout: got stuck=%0d expected 0", r, timeout); end
      n_cmp++; if (got_reads.size() !== exp_reads.size()) begin n_err++; $display("FAIL rnd%0d_nreads: got %0d expected %0d", r, got_reads.size(), exp_reads.size()); end
      n_cmp++; if (got_bytes.size() !== exp_bytes.size()) begin n_err++; $display("FAIL rnd%0d_nbytes: got %0d expected %0d", r, got_bytes.size(), exp_bytes.size()); end
      foreach (exp_bytes[i]) if (i < got_bytes.size()) begin n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_err++; $display("FAIL rnd%0d_byte[%0d]: got %h expected %h", r, i, got_bytes[i], exp_bytes[i]); end end
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rnd%0d_done: got %0d pulses expected 1", r, done_cnt); end
      n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL rnd%0d_timing: got %0d violations expected 0", r, viol); end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; reverse = 1'b0;
    start_word = '0; end_word = '0;
    bus.flash_waitrequest = 1'b0; bus.flash_readdatavalid = 1'b0;
    bus.flash_readdata = '0; bus.byte_ready = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_backpressure();
    test_waitrequest();
    test_stop_drain();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
